// File: rtl/masked_sbox_compress.sv
// masked_sbox_compress: registers 27 masked component terms per coordinate, compresses them to three refreshed output shares
`timescale 1ns/1ps
module masked_sbox_compress #(
  parameter int NCOORD = 4,
  parameter int NTERM  = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCOORD*NTERM-1:0] cf,
  input  logic [2*NCOORD-1:0]     rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCOORD-1:0]       s1,
  output logic [NCOORD-1:0]       s2,
  output logic [NCOORD-1:0]       s3,
  output logic [3:0]              out_idx,
  output logic                    out_last
);
  localparam int G = NTERM / 3;
  logic [NCOORD*NTERM-1:0] a_cf;
  logic                    a_valid;
  logic                    b_free;
  logic                    in_fire;
  logic                    ab_fire;
  logic                    out_fire;
  logic [NCOORD-1:0]       x1;
  logic [NCOORD-1:0]       x2;
  logic [NCOORD-1:0]       x3;
  logic [NCOORD-1:0]       r_lo;
  logic [NCOORD-1:0]       r_hi;
  assign b_free   = !out_valid || out_ready;
  assign in_ready = !a_valid || b_free;
  assign in_fire  = in_valid && in_ready;
  assign ab_fire  = a_valid && b_free;
  assign out_fire = out_valid && out_ready;
  assign out_last = out_idx == 4'd15;
  assign r_lo     = rnd[NCOORD-1:0];
  assign r_hi     = rnd[2*NCOORD-1:NCOORD];
  for (genvar j = 0; j < NCOORD; j++) begin : g_coord
    assign x1[j] = ^a_cf[NTERM*j +: G];
    assign x2[j] = ^a_cf[NTERM*j+G +: G];
    assign x3[j] = ^a_cf[NTERM*j+2*G +: G];
  end
  // Stage A: raw term register acting as glitch barrier before any XOR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_cf    <= '0;
    end else begin
      a_valid <= in_fire || (a_valid && !ab_fire);
      if (in_fire) a_cf <= cf;
    end
  end
  // Stage B: compressed shares refreshed with rnd sampled only on the load edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
    end else begin
      out_valid <= ab_fire || (out_valid && !out_fire);
      if (ab_fire) begin
        s1 <= x1 ^ r_lo;
        s2 <= x2 ^ r_hi;
        s3 <= x3 ^ r_lo ^ r_hi;
      end
    end
  end
  // Nibble position within the 64-bit state, advanced per output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_idx <= 4'd0;
    else if (out_fire) out_idx <= out_idx + 4'd1;
  end
endmodule

// File: tb/tb_masked_sbox_compress.sv
// tb_masked_sbox_compress: random and directed checks of the masked S-box compression pipeline against a queue model
`timescale 1ns/1ps
module tb_masked_sbox_compress;
  localparam int N = 4;
  localparam int T = 27;
  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*T-1:0] cf;
  logic [2*N-1:0] rnd;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   s1;
  logic [N-1:0]   s2;
  logic [N-1:0]   s3;
  logic [3:0]     out_idx;
  logic           out_last;
  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  int n_last = 0;
  int n_rdy_low = 0;
  logic [N*T-1:0] q[$];
  logic           ev = 1'b0;
  logic [3:0]     ei = 4'd0;
  logic [3*N-1:0] es = '0;
  logic [N*T-1:0] ecf = '0;

  masked_sbox_compress #(.NCOORD(N), .NTERM(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cf(cf), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .s1(s1), .s2(s2), .s3(s3), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Shares as defined: each output share is the XOR of its group of 9 terms, then refreshed
  function automatic logic [3*N-1:0] shares(input logic [N*T-1:0] c, input logic [2*N-1:0] r);
    logic [N-1:0] x1, x2, x3, lo, hi;
    x1 = '0; x2 = '0; x3 = '0;
    lo = r[N-1:0];
    hi = r[2*N-1:N];
    for (int j = 0; j < N; j++)
      for (int k = 0; k < T; k++)
        if (c[T*j+k]) begin
          if (k < 9) x1[j] = ~x1[j];
          else if (k < 18) x2[j] = ~x2[j];
          else x3[j] = ~x3[j];
        end
    return {x1 ^ lo, x2 ^ hi, x3 ^ lo ^ hi};
  endfunction

  function automatic logic [N-1:0] parity(input logic [N*T-1:0] c);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N*T; i++) p[i/T] = p[i/T] ^ c[i];
    return p;
  endfunction

  function automatic logic [N*T-1:0] rand_cf();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[N*T-1:0];
  endfunction

  // Model: q holds the nibble sitting in stage A; ev/es/ei describe the output register
  always @(negedge clk) begin
    logic hs, bf, rdy;
    if (!rst_n) begin
      q.delete();
      ev = 1'b0;
      ei = 4'd0;
    end else begin
      bf  = !ev || out_ready;
      rdy = q.size() == 0 || bf;
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, rdy);
      if (ev) begin
        chk("s1", s1, es[3*N-1:2*N]);
        chk("s2", s2, es[2*N-1:N]);
        chk("s3", s3, es[N-1:0]);
        chk("share_xor", s1 ^ s2 ^ s3, parity(ecf));
        chk("out_idx", out_idx, ei);
        chk("out_last", out_last, ei == 4'd15);
      end
      if (!in_ready) n_rdy_low++;
      hs = ev && out_ready;
      if (hs) begin
        n_out++;
        if (ei == 4'd15) n_last++;
        ei = ei + 4'd1;
      end
      if (bf && q.size() > 0) begin
        ecf = q.pop_front();
        es  = shares(ecf, rnd);
        ev  = 1'b1;
      end else if (hs) ev = 1'b0;
      if (in_valid && rdy) begin
        q.push_back(cf);
        n_in++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    n_in = 0; n_out = 0; n_last = 0; n_rdy_low = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cf = '0; rnd = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_s1", s1, 0);
    chk("rst_s2", s2, 0);
    chk("rst_s3", s3, 0);
    chk("rst_idx", out_idx, 0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; cf = '0; rnd = 8'h00; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", out_valid, 0);
    step();
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("zero_s1", s1, 4'h0);
    chk("zero_s2", s2, 4'h0);
    chk("zero_s3", s3, 4'h0);
    chk("zero_idx", out_idx, 0);
    step();
    in_valid = 1'b1; cf = 1; rnd = 8'h21;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("bit0_valid", out_valid, 1);
    chk("bit0_s1", s1, 4'h0);
    chk("bit0_s2", s2, 4'h2);
    chk("bit0_s3", s3, 4'h3);
    chk("bit0_idx", out_idx, 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      in_valid = 1'b1; cf = rand_cf(); rnd = 8'($urandom);
    end
    step();
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("b2b_outputs", n_out, 16);
    chk("b2b_last", n_last, 1);
    chk("b2b_ready_low", n_rdy_low, 0);
    chk("b2b_idx_wrap", out_idx, 0);
    do_reset();
    step();
    in_valid = 1'b1; out_ready = 1'b0; cf = rand_cf(); rnd = 8'($urandom);
    repeat (4) begin
      step();
      cf = rand_cf(); rnd = 8'($urandom);
    end
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    repeat (10) begin
      step();
      cf = rand_cf(); rnd = 8'($urandom);
    end
    in_valid = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("stall_balance", n_out, n_in);
    chk("stall_drained", out_valid, 0);
    do_reset();
    for (int c = 0; c < 60000 && n_in < 10000; c++) begin
      step();
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      cf = rand_cf(); rnd = 8'($urandom);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("rand_count", n_in >= 10000, 1);
    chk("rand_balance", n_out, n_in);
    do_reset();
    out_ready = 1'b0;
    step();
    in_valid = 1'b1; cf = rand_cf(); rnd = 8'($urandom);
    repeat (3) step();
    @(negedge clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    step();
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_s1", s1, 0);
    step();
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b1; cf = rand_cf(); rnd = 8'($urandom);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_idx", out_idx, 0);
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
